// File: rtl/protobuf_pkg.sv
// Constants shared by the protobuf varint serializer/deserializer pair.
package protobuf_pkg;

  localparam int VARINT_MAX_BYTES = 10;

  localparam logic [7:0] ADDR_RD64   = 8'h00;
  localparam logic [7:0] ADDR_RD32   = 8'h01;
  localparam logic [7:0] ADDR_STATUS = 8'h10;

  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  typedef logic r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

endpackage

// File: rtl/protobuf_result_fifo.sv
// Decoded-value FIFO; a push while full is taken only alongside a pop.
module protobuf_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/protobuf_deserializer.sv
// AXI4 slave: varint wire bytes in on W, decoded integers out on R.
//   state  | meaning
//   W_IDLE | waiting for AW
//   W_DATA | consuming one wire byte per W beat
//   W_RESP | holding B until bready
//   R_IDLE | waiting for AR
//   R_DATA | presenting beats; FIFO beats wait for data
module protobuf_deserializer
  import protobuf_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_BYTES = VARINT_MAX_BYTES
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic [3:0]  axs_s0_awid,
  input  logic [15:0] axs_s0_awaddr,
  input  logic [7:0]  axs_s0_awlen,
  input  logic [2:0]  axs_s0_awsize,
  input  logic [1:0]  axs_s0_awburst,
  input  logic        axs_s0_awvalid,
  output logic        axs_s0_awready,
  input  logic [31:0] axs_s0_wdata,
  input  logic [3:0]  axs_s0_wstrb,
  input  logic        axs_s0_wvalid,
  output logic        axs_s0_wready,
  output logic [3:0]  axs_s0_bid,
  output logic        axs_s0_bvalid,
  input  logic        axs_s0_bready,
  input  logic [3:0]  axs_s0_arid,
  input  logic [15:0] axs_s0_araddr,
  input  logic [7:0]  axs_s0_arlen,
  input  logic [2:0]  axs_s0_arsize,
  input  logic [1:0]  axs_s0_arburst,
  input  logic        axs_s0_arvalid,
  output logic        axs_s0_arready,
  output logic [3:0]  axs_s0_rid,
  output logic [31:0] axs_s0_rdata,
  output logic        axs_s0_rlast,
  output logic        axs_s0_rvalid,
  input  logic        axs_s0_rready
);
  localparam int IW = $clog2(MAX_BYTES + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          live;
  w_state_t      w_state;
  logic [8:0]    w_left;
  r_state_t      r_state;
  logic [7:0]    r_addr;
  logic [8:0]    r_left;
  logic          r_odd;
  logic          r_pop_beat;
  logic [63:0]   acc;
  logic [63:0]   acc_next;
  logic [IW-1:0] idx;
  logic [7:0]    shamt;
  logic          err;
  logic          err_set;
  logic          at_limit;
  logic          aw_hs, w_hs, ar_hs, byte_en;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   beat_data;
  logic          beat_fifo, beat_pops, status_rd, beat_ready, beat_load;
  logic          unused_ok;

  assign unused_ok = ^{axs_s0_awaddr, axs_s0_awsize, axs_s0_awburst, axs_s0_arsize,
                       axs_s0_arburst, axs_s0_araddr[15:8], axs_s0_wdata[31:8],
                       axs_s0_wstrb[3:1]};

  assign axs_s0_awready = live && (w_state == W_IDLE);
  assign axs_s0_arready = live && (r_state == R_IDLE);
  assign axs_s0_bvalid  = (w_state == W_RESP);
  // Only a terminating byte needs a FIFO slot; a same-cycle pop frees one.
  assign axs_s0_wready  = (w_state == W_DATA) &&
                          !(fifo_full && !axs_s0_wdata[7] && !fifo_pop);

  assign aw_hs   = axs_s0_awvalid && axs_s0_awready;
  assign w_hs    = axs_s0_wvalid && axs_s0_wready;
  assign ar_hs   = axs_s0_arvalid && axs_s0_arready;
  assign byte_en = w_hs && axs_s0_wstrb[0];

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) live <= 1'b0;
    else             live <= 1'b1;
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      w_state    <= W_IDLE;
      w_left     <= '0;
      axs_s0_bid <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          axs_s0_bid <= axs_s0_awid;
          w_left     <= {1'b0, axs_s0_awlen} + 9'd1;
          w_state    <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_left <= w_left - 9'd1;
          if (w_left == 9'd1) w_state <= W_RESP;
        end
        W_RESP: if (axs_s0_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Groups past bit 63 shift out, so 10-byte negatives land exactly.
  assign shamt     = 8'(idx) * 8'd7;
  assign acc_next  = acc | (64'(axs_s0_wdata[6:0]) << shamt);
  assign at_limit  = (idx == IW'(MAX_BYTES - 1));
  assign fifo_push = byte_en && !axs_s0_wdata[7];
  assign err_set   = byte_en && axs_s0_wdata[7] && at_limit;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
    end else begin
      if (byte_en) begin
        if (!axs_s0_wdata[7] || at_limit) begin
          acc <= '0;
          idx <= '0;
        end else begin
          acc <= acc_next;
          idx <= idx + IW'(1);
        end
      end
      err <= (err && !(beat_load && status_rd)) || err_set;
    end
  end

  protobuf_result_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk   (clock_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .data  (acc_next),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    beat_data = '0;
    beat_fifo = 1'b0;
    beat_pops = 1'b0;
    status_rd = 1'b0;
    case (r_addr)
      ADDR_RD32: begin
        beat_data = fifo_head[31:0];
        beat_fifo = 1'b1;
        beat_pops = 1'b1;
      end
      ADDR_RD64: begin
        beat_data = r_odd ? fifo_head[63:32] : fifo_head[31:0];
        beat_fifo = 1'b1;
        beat_pops = r_odd;
      end
      ADDR_STATUS: begin
        beat_data = {err, 23'b0, 8'(fifo_count)};
        status_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // rdata is registered at load so status beats hold still under backpressure.
  assign beat_ready = !beat_fifo || !fifo_empty;
  assign beat_load  = (r_state == R_DATA) && !axs_s0_rvalid && beat_ready;
  assign fifo_pop   = axs_s0_rvalid && axs_s0_rready && r_pop_beat;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_left        <= '0;
      r_odd         <= 1'b0;
      r_pop_beat    <= 1'b0;
      axs_s0_rid    <= '0;
      axs_s0_rdata  <= '0;
      axs_s0_rlast  <= 1'b0;
      axs_s0_rvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          axs_s0_rid <= axs_s0_arid;
          r_addr     <= axs_s0_araddr[7:0];
          r_left     <= {1'b0, axs_s0_arlen} + 9'd1;
          r_odd      <= 1'b0;
          r_state    <= R_DATA;
        end
        R_DATA: begin
          if (axs_s0_rvalid) begin
            if (axs_s0_rready) begin
              axs_s0_rvalid <= 1'b0;
              axs_s0_rlast  <= 1'b0;
              r_odd         <= ~r_odd;
              if (axs_s0_rlast) r_state <= R_IDLE;
            end
          end else if (beat_load) begin
            axs_s0_rvalid <= 1'b1;
            axs_s0_rdata  <= beat_data;
            axs_s0_rlast  <= (r_left == 9'd1);
            r_left        <= r_left - 9'd1;
            r_pop_beat    <= beat_pops;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_protobuf_deserializer.sv
// Scoreboard bench: a varint reference model queues expected values as bytes are written.
module tb_protobuf_deserializer;
  logic        clock_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [3:0]  awid = '0;
  logic [15:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [15:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_acc = '0;
  int          m_idx = 0;
  bit          m_err = 1'b0;
  logic [31:0] rd_log[$];
  logic [7:0]  wb[$];
  bit          ws[$];

  protobuf_deserializer #(.DEPTH(8), .MAX_BYTES(10)) dut (
    .clock_clk(clock_clk), .reset_reset(reset_reset),
    .axs_s0_awid(awid), .axs_s0_awaddr(awaddr), .axs_s0_awlen(awlen),
    .axs_s0_awsize(awsize), .axs_s0_awburst(awburst),
    .axs_s0_awvalid(awvalid), .axs_s0_awready(awready),
    .axs_s0_wdata(wdata), .axs_s0_wstrb(wstrb), .axs_s0_wvalid(wvalid),
    .axs_s0_wready(wready),
    .axs_s0_bid(bid), .axs_s0_bvalid(bvalid), .axs_s0_bready(bready),
    .axs_s0_arid(arid), .axs_s0_araddr(araddr), .axs_s0_arlen(arlen),
    .axs_s0_arsize(arsize), .axs_s0_arburst(arburst),
    .axs_s0_arvalid(arvalid), .axs_s0_arready(arready),
    .axs_s0_rid(rid), .axs_s0_rdata(rdata), .axs_s0_rlast(rlast),
    .axs_s0_rvalid(rvalid), .axs_s0_rready(rready)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input bit s);
    if (!s) return;
    m_acc |= 64'(b[6:0]) << (7 * m_idx);
    if (!b[7]) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
      m_idx = 0;
    end else if (m_idx + 1 == 10) begin
      m_err = 1'b1;
      m_acc = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endfunction

  function automatic logic [31:0] model_rdata(input logic [7:0] addr, input int beat);
    logic [63:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
    case (addr)
      8'h01:   return h[31:0];
      8'h00:   return beat[0] ? h[63:32] : h[31:0];
      8'h10:   return {m_err, 23'h0, 8'(exp_q.size())};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_retire(input logic [7:0] addr, input int beat);
    if ((addr == 8'h01 || (addr == 8'h00 && beat[0])) && exp_q.size() != 0)
      void'(exp_q.pop_front());
    if (addr == 8'h10) m_err = 1'b0;
  endfunction

  task automatic do_aw(input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awid = id; awlen = len; awaddr = 16'h0; awsize = 3'd0; awburst = 2'd0; awvalid = 1'b1;
    @(negedge clock_clk);
    while (!awready && n < 100) begin @(negedge clock_clk); n++; end
    if (!awready) chk("aw_timeout", awready, 1);
    @(posedge clock_clk); #1 awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] b, input bit s);
    int n = 0;
    wdata = {24'h0, b}; wstrb = {3'b0, s}; wvalid = 1'b1;
    @(negedge clock_clk);
    while (!wready && n < 100) begin @(negedge clock_clk); n++; end
    if (!wready) chk("w_timeout", wready, 1);
    @(posedge clock_clk); #1 wvalid = 1'b0;
    model_byte(b, s);
  endtask

  // Entered at a negedge.
  task automatic do_b(input logic [3:0] id);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 100) begin @(negedge clock_clk); n++; end
    if (!bvalid) chk("b_timeout", bvalid, 1);
    chk("bid", bid, id);
    @(posedge clock_clk); #1 bready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id);
    do_aw(id, 8'(wb.size() - 1));
    for (int i = 0; i < wb.size(); i++) do_w(wb[i], ws[i]);
    @(negedge clock_clk);
    chk("bvalid_after_last_w", bvalid, 1);
    do_b(id);
    wb.delete();
    ws.delete();
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len);
    int n = 0;
    arid = id; araddr = {8'h0, addr}; arlen = len; arsize = 3'd2; arburst = 2'd0; arvalid = 1'b1;
    @(negedge clock_clk);
    while (!arready && n < 100) begin @(negedge clock_clk); n++; end
    if (!arready) chk("ar_timeout", arready, 1);
    @(posedge clock_clk); #1 arvalid = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [7:0] addr, input int beat,
                        input bit last, input bit bp_chk);
    int n = 0;
    logic [31:0] want;
    rready = 1'b1;
    @(negedge clock_clk);
    while (!rvalid && n < 200) begin @(negedge clock_clk); n++; end
    if (!rvalid) chk("r_timeout", rvalid, 1);
    want = model_rdata(addr, beat);
    chk("rdata", rdata, want);
    chk("rlast", rlast, last);
    chk("rid", rid, id);
    if (bp_chk) chk("bp_wready_at_pop", wready, 1);
    rd_log.push_back(rdata);
    @(posedge clock_clk); #1 rready = 1'b0;
    model_retire(addr, beat);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [7:0] addr, input int len);
    rd_log.delete();
    do_ar(id, addr, 8'(len));
    for (int b = 0; b <= len; b++) r_beat(id, addr, b, b == len, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clock_clk);
    @(negedge clock_clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clock_clk); #1 reset_reset = 1'b0;
    @(negedge clock_clk);
    chk("awready_before_edge", awready, 0);
    @(negedge clock_clk);
    chk("awready_after_edge", awready, 1);
    chk("arready_after_edge", arready, 1);
    @(posedge clock_clk); #1;

    // Small values in one burst
    wb = '{8'h0a, 8'h7f, 8'h80, 8'h01};
    ws = '{1'b1, 1'b1, 1'b1, 1'b1};
    write_burst(4'h3);
    read_burst(4'h5, 8'h01, 2);
    chk("t1_beat0", rd_log[0], 32'd10);
    chk("t1_beat1", rd_log[1], 32'd127);
    chk("t1_beat2", rd_log[2], 32'd128);
    read_burst(4'h6, 8'h20, 0);
    chk("unmapped", rd_log[0], 32'h0);

    // Multi-byte value with a masked beat that must be ignored
    wb = '{8'h8a, 8'h9f, 8'hd2, 8'hf5, 8'hff, 8'h0a};
    ws = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    write_burst(4'h9);
    read_burst(4'h1, 8'h01, 0);
    chk("t2_value", rd_log[0], 32'haeb48f8a);

    // 10-byte -1
    repeat (9) begin wb.push_back(8'hff); ws.push_back(1'b1); end
    wb.push_back(8'h01); ws.push_back(1'b1);
    write_burst(4'h4);
    read_burst(4'h2, 8'h00, 1);
    chk("t3_low", rd_log[0], 32'hffffffff);
    chk("t3_high", rd_log[1], 32'hffffffff);
    read_burst(4'h2, 8'h10, 0);
    chk("t3_status", rd_log[0], 32'h0);

    // 64-bit read
    wb = '{8'h8a, 8'h9f, 8'hd2, 8'hf5, 8'hea, 8'h80, 8'h02};
    ws = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    write_burst(4'hc);
    read_burst(4'hd, 8'h00, 1);
    chk("t4_low", rd_log[0], 32'haeb48f8a);
    chk("t4_high", rd_log[1], 32'h00000806);

    // Full FIFO: terminator held off until a pop frees a slot
    repeat (8) begin wb.push_back(8'h05); ws.push_back(1'b1); end
    write_burst(4'h1);
    read_burst(4'h3, 8'h10, 0);
    chk("t5_full_count", rd_log[0], 32'h8);
    do_aw(4'h2, 8'd0);
    wdata = 32'h05; wstrb = 4'h1; wvalid = 1'b1;
    repeat (3) begin
      @(negedge clock_clk);
      chk("bp_wready_low", wready, 0);
    end
    @(posedge clock_clk); #1;
    do_ar(4'h7, 8'h01, 8'd0);
    r_beat(4'h7, 8'h01, 0, 1'b1, 1'b1);
    wvalid = 1'b0;
    model_byte(8'h05, 1'b1);
    @(negedge clock_clk);
    do_b(4'h2);
    read_burst(4'h8, 8'h01, 7);
    chk("t5_last_value", rd_log[7], 32'h5);
    read_burst(4'h3, 8'h10, 0);
    chk("t5_drained", rd_log[0], 32'h0);

    // Overlong varint sets sticky err, cleared by a status read
    repeat (11) begin wb.push_back(8'h80); ws.push_back(1'b1); end
    write_burst(4'h6);
    read_burst(4'h3, 8'h10, 0);
    chk("t6_err_set", rd_log[0], 32'h80000000);
    read_burst(4'h3, 8'h10, 0);
    chk("t6_err_cleared", rd_log[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule
